// File: rtl/dmux_8way_deser.sv
// dmux_8way_deser: bit-serial to parallel deserializer.
// Collects WIDTH bits LSB first from a valid/ready bit stream, then presents the
// assembled word on a valid/ready word stream. It alternates between collecting
// bits and holding the finished word until the consumer takes it.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-high reset
//   flush      synchronous abort of the partial word (ignored while holding)
//   in_valid   in_bit is valid this cycle
//   in_bit     serial data bit
//   in_ready   block accepts a bit this cycle (collecting)
//   out_valid  out_word holds a complete word (holding)
//   out_ready  consumer takes out_word this cycle
//   out_word   assembled word, bit i = i-th accepted bit
//   bit_cnt    bits accepted into the current word
//   out_any    (OR_FLAG_EN only) OR of all bits accepted into the current word
//
// Build option: define OR_FLAG_EN to add the registered out_any output.

module dmux_8way_deser #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [CW-1:0]    bit_cnt
`ifdef OR_FLAG_EN
    ,
    output logic             out_any
`endif
);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             any_q, any_d;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        any_d   = any_q;
        unique case (state_q)
            StCollect: begin
                // flush wins over a bit presented in the same cycle
                if (flush) begin
                    cnt_d  = '0;
                    word_d = '0;
                    any_d  = 1'b0;
                end else if (in_valid) begin
                    word_d[cnt_q] = in_bit;
                    any_d         = any_q | in_bit;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StCollect;
                    any_d   = 1'b0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCollect;
            word_q  <= '0;
            cnt_q   <= '0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            any_q   <= any_d;
        end
    end

    assign in_ready  = (state_q == StCollect);
    assign out_valid = (state_q == StHold);
    assign out_word  = word_q;
    assign bit_cnt   = cnt_q;

`ifdef OR_FLAG_EN
    assign out_any = any_q;
`else
    // Flag register has no output in this build; it is trimmed by synthesis.
    logic unused_any;
    assign unused_any = any_q;
`endif

endmodule

// File: tb/tb_dmux_8way_deser.sv
// Self-checking bench for dmux_8way_deser (WIDTH=8). A driver pushes each
// complete word it sends into a scoreboard queue; a monitor pops and compares
// on every output handshake. Directed checks cover reset, back-pressure,
// flush, asynchronous reset mid-word and back-to-back timing.

module tb_dmux_8way_deser;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [2:0]       bit_cnt;
`ifdef OR_FLAG_EN
    logic             out_any;
`endif

    dmux_8way_deser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .bit_cnt   (bit_cnt)
`ifdef OR_FLAG_EN
        ,
        .out_any   (out_any)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int pop_cycle[$];
    logic [WIDTH-1:0] exp_q[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Scoreboard monitor: inputs change #1 after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 32'(out_word), 32'hdead);
            end else begin
                check_eq("sb_word", 32'(out_word), 32'(exp_q.pop_front()));
                pop_cycle.push_back(cycle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit and hold it until accepted; bounded wait.
    task automatic send_bit(input logic b);
        logic ok;
        int   n;
        n        = 0;
        in_valid = 1'b1;
        in_bit   = b;
        forever begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
            n++;
            if (n > 50) begin
                check_eq("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < int'(WIDTH); i++) begin
            send_bit(w[i]);
            if (i == int'(WIDTH) - 1) exp_q.push_back(w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_word", 32'(out_word), 32'd0);
        check_eq("rst_bit_cnt", 32'(bit_cnt), 32'd0);
`ifdef OR_FLAG_EN
        check_eq("rst_out_any", 32'(out_any), 32'd0);
`endif
        tick();

        // 1: 1,0,1,1,0,0,1,0 LSB first -> 0x4D, one-cycle valid pulse
        send_word(8'h4D);
        @(negedge clk);
        check_eq("t1_valid", 32'(out_valid), 32'd1);
        check_eq("t1_word", 32'(out_word), 32'h4D);
        tick();
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(out_valid), 32'd0);
        tick();

        // 2: back-pressure for 5 cycles; flush during hold is ignored
        out_ready = 1'b0;
        send_word(8'h4D);
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            @(negedge clk);
            check_eq("t2_valid", 32'(out_valid), 32'd1);
            check_eq("t2_in_ready", 32'(in_ready), 32'd0);
            check_eq("t2_word", 32'(out_word), 32'h4D);
            tick();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check_eq("t2_resume", 32'(in_ready), 32'd1);
        tick();

        // 3: flush with a bit present drops it and clears the partial word
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("t3_cnt", 32'(bit_cnt), 32'd0);
        check_eq("t3_word", 32'(out_word), 32'd0);
        tick();
        send_word(8'hFF);
        tick();
        tick();

        // 4: asynchronous reset between edges after 5 bits
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("t4_word", 32'(out_word), 32'd0);
        check_eq("t4_cnt", 32'(bit_cnt), 32'd0);
        check_eq("t4_valid", 32'(out_valid), 32'd0);
        check_eq("t4_in_ready", 32'(in_ready), 32'd1);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        @(negedge clk);
        check_eq("t4_no_valid", 32'(out_valid), 32'd0);
        tick();

        // 5: back-to-back words, valid pulses 9 cycles apart
        pop_cycle.delete();
        send_word(8'hA5);
        send_word(8'h3C);
        tick();
        tick();
        check_eq("t5_pulses", 32'(pop_cycle.size()), 32'd2);
        if (pop_cycle.size() == 2)
            check_eq("t5_spacing", 32'(pop_cycle[1] - pop_cycle[0]), 32'd9);

`ifdef OR_FLAG_EN
        // 6: OR flag during hold
        out_ready = 1'b0;
        send_word(8'h00);
        @(negedge clk);
        check_eq("t6_any0", 32'(out_any), 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_word(8'h80);
        @(negedge clk);
        check_eq("t6_any1", 32'(out_any), 32'd1);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
`endif

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
